// File: rtl/option_menu_ctrl_pkg.sv
// Shared types for the options-page controller: FSM states, button
// priority encoding and the default key-code width.
package option_pkg;

  localparam int KEY_W_DEF = 5;

  typedef enum logic [1:0] {
    NAV,
    WAIT_KEY,
    COMMIT
  } state_e;

  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_ENTER,
    BTN_UP,
    BTN_DOWN,
    BTN_LEFT,
    BTN_RIGHT
  } btn_e;

  // Collapse simultaneous presses to one action: enter > up > down > left > right.
  function automatic btn_e btn_pri(input logic enter, input logic up,
                                   input logic down, input logic left,
                                   input logic right);
    if (enter) return BTN_ENTER;
    if (up)    return BTN_UP;
    if (down)  return BTN_DOWN;
    if (left)  return BTN_LEFT;
    if (right) return BTN_RIGHT;
    return BTN_NONE;
  endfunction

endpackage

// File: rtl/option_menu_ctrl_if.sv
// Button/key inputs and renderer-facing state of the options page.
// master drives buttons and keys, slave is the controller.
interface option_menu_ctrl_if #(
  parameter int NUM_BINDS = 4,
  parameter int KEY_W     = option_pkg::KEY_W_DEF,
  parameter int VOL_W     = 4
);
  localparam int IDX_W = $clog2(NUM_BINDS);

  logic                       btn_up;
  logic                       btn_down;
  logic                       btn_left;
  logic                       btn_right;
  logic                       btn_enter;
  logic                       key_valid;
  logic [KEY_W-1:0]           key_code;

  logic                       which;
  logic [IDX_W-1:0]           wasd;
  logic [NUM_BINDS*KEY_W-1:0] bind_codes;
  logic [VOL_W-1:0]           volume;
  logic [3:0]                 vol_tens;
  logic [3:0]                 vol_ones;
  logic                       rebind_busy;
  logic                       blink;
  logic                       dup_err;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_enter, key_valid, key_code,
    input  which, wasd, bind_codes, volume, vol_tens, vol_ones,
           rebind_busy, blink, dup_err
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_enter, key_valid, key_code,
    output which, wasd, bind_codes, volume, vol_tens, vol_ones,
           rebind_busy, blink, dup_err
  );
endinterface

// File: rtl/option_menu_ctrl_vol_bcd.sv
// Registered binary to two decimal digits (input range 0..99).
module vol_bcd #(
  parameter int W       = 4,
  parameter int RST_VAL = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] bin,
  output logic [3:0]   tens,
  output logic [3:0]   ones
);

  // Split into digits one cycle behind the binary value.
  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= 4'(RST_VAL / 10);
      ones <= 4'(RST_VAL % 10);
    end else begin
      tens <= 4'(int'(bin) / 10);
      ones <= 4'(int'(bin) % 10);
    end
  end

endmodule

// File: rtl/option_menu_ctrl.sv
// Options-page controller: cursor, key bindings, volume and the rebind FSM.
// OPTION_BIND_SWAP_EN: when defined, a duplicate key swaps the two slots
// instead of rejecting the rebind with a dup_err pulse.
module option_menu_ctrl
  import option_pkg::*;
#(
  parameter int                         NUM_BINDS     = 4,
  parameter int                         KEY_W         = KEY_W_DEF,
  parameter int                         VOL_W         = 4,
  parameter int                         VOL_MAX       = 15,
  parameter int                         VOL_DEFAULT   = 8,
  parameter logic [NUM_BINDS*KEY_W-1:0] DEFAULT_BINDS = {5'd3, 5'd2, 5'd1, 5'd0},
  parameter int                         TIMEOUT_CYC   = 25_000_000,
  parameter int                         BLINK_CYC     = 6_250_000
)(
  input logic               clk_25MHz,
  input logic               rst,
  option_menu_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_BINDS);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int BLK_W = $clog2(BLINK_CYC + 1);

  typedef logic [NUM_BINDS-1:0][KEY_W-1:0] binds_t;

  state_e           state_q, state_nxt;
  btn_e             act;
  logic             which_q, which_n;
  logic [IDX_W-1:0] wasd_q, wasd_n;
  binds_t           binds_q, binds_n;
  logic [VOL_W-1:0] vol_q, vol_n;
  logic [KEY_W-1:0] pend_q, pend_n;
  logic             hit_q, hit_n;
  logic             dup_c;
  logic [TMO_W-1:0] tmo_q, tmo_n;
  logic [BLK_W-1:0] bcnt_q, bcnt_n;
  logic             busy_q, busy_n;
  logic             blink_q, blink_n;
  logic             dup_q, dup_n;
  logic [3:0]       tens_w, ones_w;
`ifdef OPTION_BIND_SWAP_EN
  logic [IDX_W-1:0] idx_q, idx_n, idx_c;
`endif

  assign act = btn_pri(bus.btn_enter, bus.btn_up, bus.btn_down,
                       bus.btn_left, bus.btn_right);

  // Find an existing slot (other than the cursor's) already holding key_code.
  always_comb begin
    dup_c = 1'b0;
`ifdef OPTION_BIND_SWAP_EN
    idx_c = '0;
`endif
    for (int j = NUM_BINDS - 1; j >= 0; j--) begin
      if (IDX_W'(j) != wasd_q && binds_q[j] == bus.key_code) begin
        dup_c = 1'b1;
`ifdef OPTION_BIND_SWAP_EN
        idx_c = IDX_W'(j);
`endif
      end
    end
  end

  // State register.
  always_ff @(posedge clk_25MHz) begin
    if (rst) state_q <= NAV;
    else     state_q <= state_nxt;
  end

  // Next state: enter always cancels a pending rebind, ahead of a key.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      NAV:      if (act == BTN_ENTER && which_q) state_nxt = WAIT_KEY;
      WAIT_KEY: begin
        if (bus.btn_enter)                          state_nxt = NAV;
        else if (bus.key_valid)                     state_nxt = COMMIT;
        else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) state_nxt = NAV;
      end
      COMMIT:   state_nxt = NAV;
      default:  state_nxt = NAV;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    which_n = which_q;
    wasd_n  = wasd_q;
    binds_n = binds_q;
    vol_n   = vol_q;
    pend_n  = pend_q;
    hit_n   = hit_q;
    tmo_n   = tmo_q;
    dup_n   = 1'b0;
`ifdef OPTION_BIND_SWAP_EN
    idx_n   = idx_q;
`endif
    case (state_q)
      NAV: begin
        case (act)
          BTN_ENTER: tmo_n   = '0;
          BTN_UP:    which_n = 1'b1;
          BTN_DOWN:  which_n = 1'b0;
          BTN_LEFT: begin
            if (which_q)
              wasd_n = (wasd_q == '0) ? IDX_W'(NUM_BINDS - 1) : wasd_q - IDX_W'(1);
            else if (vol_q != '0)
              vol_n = vol_q - VOL_W'(1);
          end
          BTN_RIGHT: begin
            if (which_q)
              wasd_n = (wasd_q == IDX_W'(NUM_BINDS - 1)) ? '0 : wasd_q + IDX_W'(1);
            else if (vol_q != VOL_W'(VOL_MAX))
              vol_n = vol_q + VOL_W'(1);
          end
          default: ;
        endcase
      end
      WAIT_KEY: begin
        tmo_n = tmo_q + TMO_W'(1);
        // Duplicate check is done at capture so dup_err lines up with COMMIT.
        if (!bus.btn_enter && bus.key_valid) begin
          pend_n = bus.key_code;
          hit_n  = dup_c;
`ifdef OPTION_BIND_SWAP_EN
          idx_n  = idx_c;
`else
          dup_n  = dup_c;
`endif
        end
      end
      COMMIT: begin
`ifdef OPTION_BIND_SWAP_EN
        if (hit_q) binds_n[idx_q] = binds_q[wasd_q];
        binds_n[wasd_q] = pend_q;
`else
        if (!hit_q) binds_n[wasd_q] = pend_q;
`endif
      end
      default: ;
    endcase

    // Blink restarts low on each rebind entry and is forced low in NAV.
    busy_n  = (state_nxt != NAV);
    blink_n = 1'b0;
    bcnt_n  = '0;
    if (state_nxt != NAV && state_q != NAV) begin
      if (bcnt_q == BLK_W'(BLINK_CYC - 1)) begin
        blink_n = ~blink_q;
      end else begin
        blink_n = blink_q;
        bcnt_n  = bcnt_q + BLK_W'(1);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      which_q <= 1'b1;
      wasd_q  <= '0;
      binds_q <= DEFAULT_BINDS;
      vol_q   <= VOL_W'(VOL_DEFAULT);
      pend_q  <= '0;
      hit_q   <= 1'b0;
      tmo_q   <= '0;
      bcnt_q  <= '0;
      busy_q  <= 1'b0;
      blink_q <= 1'b0;
      dup_q   <= 1'b0;
`ifdef OPTION_BIND_SWAP_EN
      idx_q   <= '0;
`endif
    end else begin
      which_q <= which_n;
      wasd_q  <= wasd_n;
      binds_q <= binds_n;
      vol_q   <= vol_n;
      pend_q  <= pend_n;
      hit_q   <= hit_n;
      tmo_q   <= tmo_n;
      bcnt_q  <= bcnt_n;
      busy_q  <= busy_n;
      blink_q <= blink_n;
      dup_q   <= dup_n;
`ifdef OPTION_BIND_SWAP_EN
      idx_q   <= idx_n;
`endif
    end
  end

  vol_bcd #(.W(VOL_W), .RST_VAL(VOL_DEFAULT)) u_vol_bcd (
    .clk  (clk_25MHz),
    .rst  (rst),
    .bin  (vol_q),
    .tens (tens_w),
    .ones (ones_w)
  );

  assign bus.which       = which_q;
  assign bus.wasd        = wasd_q;
  assign bus.bind_codes  = binds_q;
  assign bus.volume      = vol_q;
  assign bus.vol_tens    = tens_w;
  assign bus.vol_ones    = ones_w;
  assign bus.rebind_busy = busy_q;
  assign bus.blink       = blink_q;
  assign bus.dup_err     = dup_q;

endmodule

// File: tb/tb_option_menu_ctrl.sv
// Bench for option_menu_ctrl: directed steps followed by random traffic,
// every cycle compared against a behavioural model of the options page.
module tb_option_menu_ctrl;

  localparam int NB   = 4;
  localparam int KW   = 5;
  localparam int VW   = 4;
  localparam int VMAX = 15;
  localparam int VDEF = 8;
  localparam int TO   = 40;
  localparam int BL   = 7;
  localparam logic [NB*KW-1:0] DEF_B = {5'd3, 5'd2, 5'd1, 5'd0};

  localparam int M_NAV = 0, M_WAIT = 1, M_COMMIT = 2;
  localparam int B_ENTER = 0, B_UP = 1, B_DOWN = 2, B_LEFT = 3, B_RIGHT = 4;

  logic clk_25MHz = 1'b0;
  logic rst = 1'b0;
  always #5 clk_25MHz = ~clk_25MHz;

  option_menu_ctrl_if #(.NUM_BINDS(NB), .KEY_W(KW), .VOL_W(VW)) bus ();

  option_menu_ctrl #(
    .NUM_BINDS(NB), .KEY_W(KW), .VOL_W(VW), .VOL_MAX(VMAX), .VOL_DEFAULT(VDEF),
    .DEFAULT_BINDS(DEF_B), .TIMEOUT_CYC(TO), .BLINK_CYC(BL)
  ) dut (
    .clk_25MHz (clk_25MHz),
    .rst       (rst),
    .bus       (bus)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Model of the page: plain integers, one update per clock.
  int m_which, m_wasd, m_vol, m_dsrc, m_mode, m_wait, m_busyn, m_pend;
  bit m_dup;
  int m_b[NB];

  task automatic m_reset();
    m_which = 1; m_wasd = 0; m_vol = VDEF; m_dsrc = VDEF;
    m_mode = M_NAV; m_wait = 0; m_busyn = 0; m_pend = 0; m_dup = 0;
    for (int i = 0; i < NB; i++) m_b[i] = i;
  endtask

  function automatic int find_dup(input int code);
    for (int j = 0; j < NB; j++)
      if (j != m_wasd && m_b[j] == code) return j;
    return -1;
  endfunction

  function automatic logic [NB*KW-1:0] m_pack();
    logic [NB*KW-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[i*KW +: KW] = KW'(m_b[i]);
    return v;
  endfunction

  task automatic m_step(input bit r, input bit e, input bit u, input bit d,
                        input bit l, input bit rt, input bit kv, input int kc);
    int hit;
    if (r) begin m_reset(); return; end
    m_dsrc = m_vol;
    m_dup  = 0;
    if (m_mode == M_NAV) begin
      if (e) begin
        if (m_which) begin m_mode = M_WAIT; m_wait = 0; m_busyn = 0; end
      end
      else if (u) m_which = 1;
      else if (d) m_which = 0;
      else if (l) begin
        if (m_which) m_wasd = (m_wasd + NB - 1) % NB;
        else if (m_vol > 0) m_vol--;
      end
      else if (rt) begin
        if (m_which) m_wasd = (m_wasd + 1) % NB;
        else if (m_vol < VMAX) m_vol++;
      end
    end else if (m_mode == M_WAIT) begin
      m_busyn++;
      if (e) m_mode = M_NAV;
      else if (kv) begin
        m_pend = kc;
        m_mode = M_COMMIT;
`ifndef OPTION_BIND_SWAP_EN
        m_dup = (find_dup(kc) >= 0);
`endif
      end else begin
        m_wait++;
        if (m_wait == TO) m_mode = M_NAV;
      end
    end else begin
      hit = find_dup(m_pend);
      if (hit < 0) m_b[m_wasd] = m_pend;
`ifdef OPTION_BIND_SWAP_EN
      else begin m_b[hit] = m_b[m_wasd]; m_b[m_wasd] = m_pend; end
`endif
      m_mode = M_NAV;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("which",  64'(bus.which),       64'(m_which));
    chk("wasd",   64'(bus.wasd),        64'(m_wasd));
    chk("binds",  64'(bus.bind_codes),  64'(m_pack()));
    chk("volume", 64'(bus.volume),      64'(m_vol));
    chk("tens",   64'(bus.vol_tens),    64'(m_dsrc / 10));
    chk("ones",   64'(bus.vol_ones),    64'(m_dsrc % 10));
    chk("busy",   64'(bus.rebind_busy), 64'(m_mode != M_NAV));
    chk("blink",  64'(bus.blink),       64'((m_mode != M_NAV) ? (m_busyn / BL) % 2 : 0));
    chk("dup",    64'(bus.dup_err),     64'(m_dup));
  endtask

  // One clock with the given inputs; outputs sampled 1 after the edge.
  task automatic cyc(input bit r, input bit e, input bit u, input bit d,
                     input bit l, input bit rt, input bit kv, input int kc);
    rst = r;
    bus.btn_enter = e; bus.btn_up = u; bus.btn_down = d;
    bus.btn_left = l; bus.btn_right = rt;
    bus.key_valid = kv; bus.key_code = KW'(kc);
    m_step(r, e, u, d, l, rt, kv, kc);
    @(posedge clk_25MHz);
    #1;
    rst = 0;
    bus.btn_enter = 0; bus.btn_up = 0; bus.btn_down = 0;
    bus.btn_left = 0; bus.btn_right = 0; bus.key_valid = 0; bus.key_code = '0;
    check_model();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic btn(input int b);
    cyc(0, b == B_ENTER, b == B_UP, b == B_DOWN, b == B_LEFT, b == B_RIGHT, 0, 0);
  endtask

  task automatic key(input int c);
    cyc(0, 0, 0, 0, 0, 0, 1, c);
  endtask

  initial begin
    int exp_w[5] = '{1, 2, 3, 0, 1};
    int own;
    rst = 0;
    bus.btn_enter = 0; bus.btn_up = 0; bus.btn_down = 0;
    bus.btn_left = 0; bus.btn_right = 0; bus.key_valid = 0; bus.key_code = '0;
    m_reset();

    // Reset values
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_which", 64'(bus.which), 64'd1);
    chk("rst_wasd",  64'(bus.wasd), 64'd0);
    chk("rst_binds", 64'(bus.bind_codes), 64'(DEF_B));
    chk("rst_vol",   64'(bus.volume), 64'd8);
    chk("rst_tens",  64'(bus.vol_tens), 64'd0);
    chk("rst_ones",  64'(bus.vol_ones), 64'd8);
    chk("rst_busy",  64'(bus.rebind_busy), 64'd0);

    // Cursor wraps on the bindings row
    for (int i = 0; i < 5; i++) begin
      btn(B_RIGHT);
      chk("wasd_wrap", 64'(bus.wasd), 64'(exp_w[i]));
    end

    // Volume saturates at the top
    btn(B_DOWN);
    for (int i = 0; i < 20; i++) btn(B_RIGHT);
    idle();
    chk("vol_sat",  64'(bus.volume), 64'd15);
    chk("vol_tens", 64'(bus.vol_tens), 64'd1);
    chk("vol_ones", 64'(bus.vol_ones), 64'd5);
    for (int i = 0; i < 20; i++) btn(B_LEFT);
    chk("vol_floor", 64'(bus.volume), 64'd0);

    // Plain rebind of slot 2 to code 9, two-cycle latency
    btn(B_UP);
    btn(B_RIGHT);
    chk("wasd_2", 64'(bus.wasd), 64'd2);
    btn(B_ENTER);
    chk("busy_wait", 64'(bus.rebind_busy), 64'd1);
    key(9);
    chk("slot2_old", 64'(bus.bind_codes[2*KW +: KW]), 64'd2);
    chk("busy_commit", 64'(bus.rebind_busy), 64'd1);
    idle();
    chk("slot2_new", 64'(bus.bind_codes[2*KW +: KW]), 64'd9);
    chk("busy_done", 64'(bus.rebind_busy), 64'd0);

    // Duplicate: slot0 asks for code 1, held by slot1
    btn(B_LEFT);
    btn(B_LEFT);
    chk("wasd_0", 64'(bus.wasd), 64'd0);
    btn(B_ENTER);
    key(1);
`ifdef OPTION_BIND_SWAP_EN
    chk("swap_dup", 64'(bus.dup_err), 64'd0);
    idle();
    chk("swap_s0", 64'(bus.bind_codes[0 +: KW]), 64'd1);
    chk("swap_s1", 64'(bus.bind_codes[KW +: KW]), 64'd0);
    own = 1;
`else
    chk("dup_pulse", 64'(bus.dup_err), 64'd1);
    idle();
    chk("dup_clear", 64'(bus.dup_err), 64'd0);
    chk("rej_s0", 64'(bus.bind_codes[0 +: KW]), 64'd0);
    chk("rej_s1", 64'(bus.bind_codes[KW +: KW]), 64'd1);
    own = 0;
`endif

    // Rewriting a slot with its own code is not a duplicate
    btn(B_ENTER);
    key(own);
    chk("own_dup", 64'(bus.dup_err), 64'd0);
    idle();
    chk("own_val", 64'(bus.bind_codes[0 +: KW]), 64'(own));

    // Timeout with blink during the wait
    btn(B_ENTER);
    for (int i = 1; i < TO; i++) begin
      idle();
      chk("blink_wait", 64'(bus.blink), 64'((i / BL) % 2));
    end
    chk("tmo_busy", 64'(bus.rebind_busy), 64'd1);
    idle();
    chk("tmo_nav", 64'(bus.rebind_busy), 64'd0);
    chk("tmo_binds", 64'(bus.bind_codes), 64'(m_pack()));

    // enter and key together: cancel wins
    btn(B_ENTER);
    cyc(0, 1, 0, 0, 0, 0, 1, 7);
    chk("cancel_busy", 64'(bus.rebind_busy), 64'd0);
    idle();
    chk("cancel_binds", 64'(bus.bind_codes), 64'(m_pack()));

    // left and right together: left acts
    cyc(0, 0, 0, 0, 1, 1, 0, 0);
    chk("lr_pri", 64'(bus.wasd), 64'd3);

    // Reset while waiting for a key
    btn(B_RIGHT);
    btn(B_ENTER);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rrst_binds", 64'(bus.bind_codes), 64'(DEF_B));
    chk("rrst_busy",  64'(bus.rebind_busy), 64'd0);
    chk("rrst_which", 64'(bus.which), 64'd1);
    key(5);
    chk("rrst_nav", 64'(bus.rebind_busy), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 19) == 0,
          int'($urandom_range(0, NB + 2)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
